// File: rtl/pdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pdm_pkg
// Description : Shared mode encoding and integrator arithmetic helpers for
//               the multichannel PDM modulator.
// Revision    : 1.0 - initial release
// ============================================================================
package pdm_pkg;

    localparam logic MODE_FIRST  = 1'b0;
    localparam logic MODE_SECOND = 1'b1;

    function automatic int i1_width(input int width);
        return width + 3;
    endfunction

    function automatic int i2_width(input int width);
        return width + 5;
    endfunction

    // Add two values and clamp the result to a w-bit two's-complement range.
    function automatic int sat_add(input int a, input int b, input int w);
        int sum;
        int hi;
        int lo;
        sum = a + b;
        hi  = (1 << (w - 1)) - 1;
        lo  = -(1 << (w - 1));
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_channel.sv
`default_nettype none
// ============================================================================
// Module      : pdm_channel
// Description : One PDM channel: input register, first-order accumulator,
//               saturating second-order integrators and output flop.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_channel
    import pdm_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             step,
    input  logic             clear,
    input  logic             mode,
    output logic             pdm
);

    localparam int c_I1_W = i1_width(WIDTH);
    localparam int c_I2_W = i2_width(WIDTH);

    logic [WIDTH-1:0]         r_in;
    logic [WIDTH-1:0]         r_acc;
    logic signed [c_I1_W-1:0] r_i1;
    logic signed [c_I2_W-1:0] r_i2;
    logic                     r_pdm;

    logic [WIDTH:0] w_sum;
    int             w_fb;
    int             w_i1_next;
    int             w_i2_next;

    // Feedback is the previous output bit scaled to full scale.
    always_comb begin
        w_sum     = {1'b0, r_in} + {1'b0, r_acc};
        w_fb      = r_pdm ? (1 << WIDTH) : 0;
        w_i1_next = sat_add(int'(r_i1), int'(r_in) - w_fb, c_I1_W);
        w_i2_next = sat_add(int'(r_i2), w_i1_next - w_fb, c_I2_W);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in  <= '0;
            r_acc <= '0;
            r_i1  <= '0;
            r_i2  <= '0;
            r_pdm <= 1'b0;
        end else begin
            if (load) begin
                r_in <= data;
            end
            if (clear) begin
                r_acc <= '0;
                r_i1  <= '0;
                r_i2  <= '0;
                r_pdm <= 1'b0;
            end else if (step) begin
                if (mode == MODE_SECOND) begin
                    r_i1  <= w_i1_next[c_I1_W-1:0];
                    r_i2  <= w_i2_next[c_I2_W-1:0];
                    r_pdm <= (w_i2_next >= 0);
                end else begin
                    r_acc <= w_sum[WIDTH-1:0];
                    r_pdm <= w_sum[WIDTH];
                end
            end
        end
    end

    assign pdm = r_pdm;

endmodule
`default_nettype wire

// File: rtl/pdm_multichannel_modulator.sv
`default_nettype none
// ============================================================================
// Module      : pdm_multichannel_modulator
// Description : CHANNELS independent first/second-order PDM modulators with a
//               shared write port, shared prescaler and runtime mode select.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_multichannel_modulator
    import pdm_pkg::*;
#(
    parameter int  WIDTH    = 5,
    parameter int  CHANNELS = 2,
    parameter int  DIV_W    = 4,
    localparam int ADDR_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                mode,
    input  logic [DIV_W-1:0]    div,
    output logic                tick,
    output logic [CHANNELS-1:0] pdm_out
);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_tick;
    logic             r_mode;

    logic w_clear;
    logic w_step;

    // A lowered div below the current count lets the counter run to its wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
            r_mode    <= MODE_FIRST;
        end else begin
            r_mode    <= mode;
            r_tick    <= (r_div_cnt == div);
            r_div_cnt <= (r_div_cnt == div) ? '0 : r_div_cnt + DIV_W'(1);
        end
    end

    assign w_clear = (mode != r_mode);
    assign w_step  = r_tick & ~w_clear;
    assign tick    = r_tick;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
        logic w_load;
        assign w_load = wr_en && (wr_addr == ADDR_W'(g));

        pdm_channel #(
            .WIDTH (WIDTH)
        ) u_channel (
            .clk   (clk),
            .reset (reset),
            .load  (w_load),
            .data  (wr_data),
            .step  (w_step),
            .clear (w_clear),
            .mode  (r_mode),
            .pdm   (pdm_out[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_pdm_multichannel_modulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdm_multichannel_modulator
// Description : Self-checking bench: directed vectors, density checks and
//               randomized traffic against a behavioural PDM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdm_multichannel_modulator;

    localparam int c_W  = 5;
    localparam int c_CH = 3;
    localparam int c_DW = 4;

    logic            clk;
    logic            reset;
    logic            wr_en;
    logic [1:0]      wr_addr;
    logic [c_W-1:0]  wr_data;
    logic            mode;
    logic [c_DW-1:0] div;
    logic            tick;
    logic [c_CH-1:0] pdm_out;

    pdm_multichannel_modulator #(
        .WIDTH    (c_W),
        .CHANNELS (c_CH),
        .DIV_W    (c_DW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .mode    (mode),
        .div     (div),
        .tick    (tick),
        .pdm_out (pdm_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Behavioural reference state, plain integers.
    int m_in  [c_CH];
    int m_acc [c_CH];
    int m_i1  [c_CH];
    int m_i2  [c_CH];
    bit m_out [c_CH];
    int m_cnt;
    bit m_tick;
    bit m_mode;

    function automatic int clamp(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic model_edge();
        bit clr;
        bit stp;
        bit nt;
        int fb;
        int s;
        if (reset) begin
            for (int c = 0; c < c_CH; c++) begin
                m_in[c] = 0; m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_out[c] = 0;
            end
            m_cnt = 0; m_tick = 0; m_mode = 0;
        end else begin
            clr = (mode != m_mode);
            stp = m_tick && !clr;
            nt  = (m_cnt == int'(div));
            for (int c = 0; c < c_CH; c++) begin
                if (clr) begin
                    m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_out[c] = 0;
                end else if (stp) begin
                    if (m_mode) begin
                        fb       = m_out[c] ? 32 : 0;
                        m_i1[c]  = clamp(m_i1[c] + m_in[c] - fb, c_W + 3);
                        m_i2[c]  = clamp(m_i2[c] + m_i1[c] - fb, c_W + 5);
                        m_out[c] = (m_i2[c] >= 0);
                    end else begin
                        s        = m_in[c] + m_acc[c];
                        m_out[c] = (s >= 32);
                        m_acc[c] = s % 32;
                    end
                end
            end
            m_cnt = nt ? 0 : (m_cnt + 1) % 16;
            if (wr_en && int'(wr_addr) < c_CH) begin
                m_in[wr_addr] = int'(wr_data);
            end
            m_mode = mode;
            m_tick = nt;
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic check_rng(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // One clock: advance the model with the applied inputs, then compare.
    task automatic cycle();
        logic [c_CH-1:0] mv;
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < c_CH; c++) mv[c] = m_out[c];
        total++;
        if (tick !== m_tick || pdm_out !== mv) begin
            bad++;
            $display("FAIL model @%0t: tick=%b pdm=%b want tick=%b pdm=%b",
                     $time, tick, pdm_out, m_tick, mv);
        end
    endtask

    task automatic drive(input bit we, input int addr, input int data,
                         input bit md, input int dv);
        wr_en   = we;
        wr_addr = 2'(addr);
        wr_data = c_W'(data);
        mode    = md;
        div     = c_DW'(dv);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    typedef struct {
        bit       we;
        int       addr;
        int       data;
        bit       md;
        int       dv;
        bit       e_tick;
        bit [2:0] e_pdm;
    } vec_t;

    vec_t vt[10];
    bit   samples[$];
    int   ones;
    int   zeros_lo;
    int   first_tick;

    initial begin
        // div=0, first-order, ch0=8: one '1' every fourth tick.
        vt[0] = '{1, 0, 8, 0, 0, 1, 3'b000};
        for (int i = 1; i < 10; i++) vt[i] = '{0, 0, 0, 0, 0, 1, 3'b000};
        vt[4].e_pdm = 3'b001;
        vt[8].e_pdm = 3'b001;

        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        cycle();
        cycle();
        check("reset_tick", int'(tick), 0);
        check("reset_pdm", int'(pdm_out), 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].we, vt[i].addr, vt[i].data, vt[i].md, vt[i].dv);
            cycle();
            check($sformatf("vec%0d_tick", i), int'(tick), int'(vt[i].e_tick));
            check($sformatf("vec%0d_pdm", i), int'(pdm_out), int'(vt[i].e_pdm));
        end

        // div=3, ch1=16: tick every 4th cycle, ch1 alternates per step.
        drive(0, 0, 0, 0, 3);
        pulse_reset();
        ones = 0;
        for (int i = 0; i < 80; i++) begin
            drive(i == 0, 1, 16, 0, 3);
            cycle();
            if (tick) begin
                ones++;
                samples.push_back(pdm_out[1]);
            end
        end
        check("div3_tick_count", ones, 20);
        for (int k = 1; k < samples.size(); k++) begin
            check($sformatf("div3_alt%0d", k), int'(samples[k]), (k % 2 == 0) ? 1 : 0);
        end

        // Out-of-range address ignored; write coinciding with a step.
        drive(0, 0, 0, 0, 0);
        pulse_reset();
        cycle();
        drive(1, 3, 31, 0, 0);
        cycle();
        drive(1, 2, 31, 0, 0);
        cycle();
        check("wr_step_old_value", int'(pdm_out[2]), 0);
        drive(0, 0, 0, 0, 0);
        ones = 0;
        zeros_lo = 0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            ones     += int'(pdm_out[2]);
            zeros_lo += int'(pdm_out[0]) + int'(pdm_out[1]);
        end
        check("ch2_31_of_32", ones, 31);
        check("addr3_ignored", zeros_lo, 0);

        // Second-order densities.
        drive(1, 0, 16, 1, 0);
        cycle();
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 64; i++) cycle();
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            cycle();
            ones += int'(pdm_out[0]);
        end
        check_rng("so_density_16", ones, 126, 130);

        drive(1, 0, 0, 1, 0);
        cycle();
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 64; i++) cycle();
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            cycle();
            ones += int'(pdm_out[0]);
        end
        check("so_density_0", ones, 0);

        drive(1, 0, 31, 1, 0);
        cycle();
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 64; i++) cycle();
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            cycle();
            ones += int'(pdm_out[0]);
        end
        check_rng("so_density_31", ones, 246, 250);

        // Mode toggle mid-run clears state but keeps inputs.
        drive(1, 1, 16, 0, 3);
        cycle();
        drive(0, 0, 0, 0, 3);
        for (int i = 0; i < 20; i++) cycle();
        drive(0, 0, 0, 1, 3);
        cycle();
        check("toggle_clear_pdm", int'(pdm_out), 0);
        ones = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            ones += int'(pdm_out[1]);
        end
        check_rng("toggle_input_kept", ones, 1, 40);

        // One-cycle reset mid-run clears inputs and restarts the prescaler.
        drive(0, 0, 0, 0, 3);
        pulse_reset();
        check("midreset_pdm", int'(pdm_out), 0);
        check("midreset_tick", int'(tick), 0);
        ones = 0;
        first_tick = -1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            ones += int'(pdm_out[0]) + int'(pdm_out[1]) + int'(pdm_out[2]);
            if (tick && first_tick < 0) first_tick = i;
        end
        check("midreset_inputs_cleared", ones, 0);
        check("midreset_first_tick", first_tick, 3);

        // Randomized traffic, including div changes below the live count.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 31),
                  ($urandom_range(0, 63) == 0) ? ~mode : mode,
                  ($urandom_range(0, 49) == 0) ? $urandom_range(0, 15) : int'(div));
            cycle();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
